pipe_addsub: RTL

//   Parametrised, pipelined adder/subtractor. Generalises the 1-bit half adder
//   to WIDTH bits with carry-in, subtract mode and signed overflow.
//   The carry chain is split into STAGES registered chunks, so WIDTH can scale

---
 rtl/pipe_addsub.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES registered chunks,
// with a single global stall and valid/ready handshakes on both sides.
module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int CH   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic             advance_s;
   logic [WIDTH-1:0] a_r       [STAGES];
   logic [WIDTH-1:0] b_r       [STAGES];
   logic [WIDTH-1:0] sum_r     [STAGES];
   logic             carry_r   [STAGES];
   logic             valid_r   [STAGES];
   logic             ovf_r;

   logic [WIDTH-1:0] src_a_s   [STAGES];
   logic [WIDTH-1:0] src_b_s   [STAGES];
   logic [WIDTH-1:0] src_sum_s [STAGES];
   logic             src_c_s   [STAGES];
   logic             src_v_s   [STAGES];
   logic [CH-1:0]    chunk_s   [STAGES];
   logic             carry_nxt_s [STAGES];
   logic [WIDTH-1:0] sum_nxt_s [STAGES];
   logic             ovf_nxt_s;

   assign advance_s = out_ready | ~out_valid;
   assign in_ready  = advance_s;

   assign out_valid = valid_r[LAST];
   assign out_sum   = sum_r[LAST];
   assign out_cout  = carry_r[LAST];
   assign out_ovf   = ovf_r;

   // Stage sources and per-stage chunk addition; B is pre-inverted for subtract.
   always_comb begin
      src_a_s[0]   = in_a;
      src_b_s[0]   = in_sub ? ~in_b : in_b;
      src_c_s[0]   = in_sub ? 1'b1 : in_cin;
      src_sum_s[0] = {WIDTH{1'b0}};
      src_v_s[0]   = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         src_a_s[k]   = a_r[k-1];
         src_b_s[k]   = b_r[k-1];
         src_c_s[k]   = carry_r[k-1];
         src_sum_s[k] = sum_r[k-1];
         src_v_s[k]   = valid_r[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         {carry_nxt_s[k], chunk_s[k]} = {1'b0, src_a_s[k][k*CH +: CH]}
                                      + {1'b0, src_b_s[k][k*CH +: CH]}
                                      + {{CH{1'b0}}, src_c_s[k]};
         sum_nxt_s[k]                 = src_sum_s[k];
         sum_nxt_s[k][k*CH +: CH]     = chunk_s[k];
      end
      // Carry into the MSB is a ^ b ^ sum at that bit.
      ovf_nxt_s = src_a_s[LAST][WIDTH-1] ^ src_b_s[LAST][WIDTH-1]
                ^ sum_nxt_s[LAST][WIDTH-1] ^ carry_nxt_s[LAST];
   end

   // Pipeline registers: all stages advance together or hold together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_r[k]     <= {WIDTH{1'b0}};
            b_r[k]     <= {WIDTH{1'b0}};
            sum_r[k]   <= {WIDTH{1'b0}};
            carry_r[k] <= 1'b0;
            valid_r[k] <= 1'b0;
         end
         ovf_r <= 1'b0;
      end else if (advance_s) begin
         for (int k = 0; k < STAGES; k++) begin
            a_r[k]     <= src_a_s[k];
            b_r[k]     <= src_b_s[k];
            sum_r[k]   <= sum_nxt_s[k];
            carry_r[k] <= carry_nxt_s[k];
            valid_r[k] <= src_v_s[k];
         end
         ovf_r <= ovf_nxt_s;
      end
   end

endmodule
